// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: single-wire bus arbiter with split tracking and an owner watchdog.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module serial_bus_arbiter #(
    parameter int N_INIT         = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_INIT-1:0] req,
    input  logic              txn_done,
    input  logic              split,
    input  logic              split_resume,
    output logic [N_INIT-1:0] grant,
    output logic [ID_W-1:0]   owner_id,
    output logic              bus_busy,
    output logic              split_pending,
    output logic              timeout,
    output logic              split_err
);
    localparam int unsigned     N_U     = N_INIT;
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
`ifndef ARB_FIXED_PRIORITY_EN
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_INIT - 1);
`endif

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   split_id_q, split_id_d;
    logic              resume_q, resume_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [N_INIT-1:0] grant_d;
    logic [ID_W-1:0]   owner_d;
    logic              busy_d, pend_d, timeout_d, split_err_d;
    logic              release_own;

    logic [N_INIT-1:0] split_oh, elig_mask, eligible;
    logic              win_vld, hit;
    logic [ID_W-1:0]   win_id;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_d;
    int unsigned       idx;
`endif

    assign split_oh = N_INIT'(1) << split_id_q;

    // Winner selection; a served resume overrides the normal scan.
    always_comb begin
        elig_mask = (split_pending && !resume_q) ? split_oh : '0;
        eligible  = req & ~elig_mask;
        win_vld   = 1'b0;
        win_id    = '0;
        hit       = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        idx       = 0;
`endif
        if (resume_q && ((req & split_oh) != '0)) begin
            win_vld = 1'b1;
            win_id  = split_id_q;
        end else begin
`ifdef ARB_FIXED_PRIORITY_EN
            for (int unsigned k = 0; k < N_U; k++) begin
                hit = (eligible & (N_INIT'(1) << k)) != '0;
                if (!win_vld && hit) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(k);
                end
            end
`else
            for (int unsigned k = 0; k < N_U; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= N_U) idx = idx - N_U;
                hit = (eligible & (N_INIT'(1) << idx)) != '0;
                if (!win_vld && hit) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(idx);
                end
            end
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant;
        owner_d     = owner_id;
        busy_d      = bus_busy;
        pend_d      = split_pending;
        split_id_d  = split_id_q;
        resume_d    = resume_q;
        wdog_d      = wdog_q;
        timeout_d   = 1'b0;
        split_err_d = 1'b0;
        release_own = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_d        = rr_ptr_q;
`endif
        if (split_resume && split_pending) resume_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = OWN;
                    grant_d = N_INIT'(1) << win_id;
                    owner_d = win_id;
                    busy_d  = 1'b1;
                    wdog_d  = '0;
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_d    = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
`endif
                end
            end
            OWN: begin
                wdog_d = wdog_q + 1'b1;
                if (split) begin
                    release_own = 1'b1;
                    if (!split_pending) begin
                        pend_d     = 1'b1;
                        split_id_d = owner_id;
                    end else begin
                        split_err_d = 1'b1;
                    end
                end else if (txn_done) begin
                    release_own = 1'b1;
                    if (split_pending && resume_q && owner_id == split_id_q) begin
                        pend_d   = 1'b0;
                        resume_d = 1'b0;
                    end
                end else if ((req & grant) == '0) begin
                    release_own = 1'b1;
                end else if (wdog_q == WD_LAST) begin
                    release_own = 1'b1;
                    timeout_d   = 1'b1;
                end
                if (release_own) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant         <= '0;
            owner_id      <= '0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b0;
            timeout       <= 1'b0;
            split_err     <= 1'b0;
            split_id_q    <= '0;
            resume_q      <= 1'b0;
            wdog_q        <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant         <= grant_d;
            owner_id      <= owner_d;
            bus_busy      <= busy_d;
            split_pending <= pend_d;
            timeout       <= timeout_d;
            split_err     <= split_err_d;
            split_id_q    <= split_id_d;
            resume_q      <= resume_d;
            wdog_q        <= wdog_d;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr_q      <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter (N_INIT=2, TIMEOUT_CYCLES=8): expected output
// changes and their spacing in cycles are queued per phase and checked by a monitor.
module tb_serial_bus_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       txn_done, split, split_resume;
    logic [1:0] grant;
    logic [2:0] owner_id;
    logic       bus_busy, split_pending, timeout, split_err;

    serial_bus_arbiter #(.N_INIT(2), .TIMEOUT_CYCLES(8), .ID_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .txn_done(txn_done), .split(split),
        .split_resume(split_resume), .grant(grant), .owner_id(owner_id),
        .bus_busy(bus_busy), .split_pending(split_pending), .timeout(timeout),
        .split_err(split_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [8:0] vec;
        int         gap;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [8:0] dut_vec;

    // {grant, owner_id, bus_busy, split_pending, timeout, split_err}
    assign dut_vec = {grant, owner_id, bus_busy, split_pending, timeout, split_err};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [1:0] g, input logic [2:0] o,
                            input logic b, input logic p, input logic t, input logic e,
                            input int gap);
        exp_t x;
        x.name = nm;
        x.vec  = {g, o, b, p, t, e};
        x.gap  = gap;
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b", nm, got, want);
        end
    endtask

    task automatic done_after(input int n, input logic [1:0] r);
        step(n);
        txn_done = 1'b1;
        req      = r;
        step(1);
        txn_done = 1'b0;
    endtask

    // Monitor: every change of the output vector pops one expectation; gap -1 = any spacing.
    initial begin
        logic [8:0] prev;
        logic [8:0] cur;
        int         cnt;
        exp_t       x;
        prev = '0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            cur = dut_vec;
            if (!mon_en) begin
                prev = cur;
                cnt  = 0;
            end else begin
                cnt++;
                if (cur !== prev) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change got %b expected no change", cur);
                    end else begin
                        x = sbq.pop_front();
                        if (cur !== x.vec || (x.gap >= 0 && cnt != x.gap)) begin
                            errors++;
                            $display("FAIL %s got vec=%b gap=%0d expected vec=%b gap=%0d",
                                     x.name, cur, cnt, x.vec, x.gap);
                        end
                    end
                    prev = cur;
                    cnt  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; req = '0; txn_done = 1'b0; split = 1'b0; split_resume = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset_state", dut_vec, '0);
        step(1);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Both requesting, each owner completes 4 cycles after its grant.
        push_exp("rr_g0",   2'b01, 3'd0, 1, 0, 0, 0, -1);
        push_exp("rr_r0",   2'b00, 3'd0, 0, 0, 0, 0, 4);
`ifdef ARB_FIXED_PRIORITY_EN
        push_exp("rr_g1",   2'b01, 3'd0, 1, 0, 0, 0, 1);
        push_exp("rr_r1",   2'b00, 3'd0, 0, 0, 0, 0, 4);
`else
        push_exp("rr_g1",   2'b10, 3'd1, 1, 0, 0, 0, 1);
        push_exp("rr_r1",   2'b00, 3'd1, 0, 0, 0, 0, 4);
`endif
        push_exp("rr_g2",   2'b01, 3'd0, 1, 0, 0, 0, 1);
        push_exp("rr_r2",   2'b00, 3'd0, 0, 0, 0, 0, 4);
        step(1);
        req = 2'b11;
        done_after(4, 2'b11);
        done_after(4, 2'b11);
        done_after(4, 2'b00);

        // Split by initiator 0, initiator 1 served while 0 is masked, resume regrants 0.
        push_exp("sp_g0",   2'b01, 3'd0, 1, 0, 0, 0, -1);
        push_exp("sp_rel",  2'b00, 3'd0, 0, 1, 0, 0, 3);
        push_exp("sp_g1",   2'b10, 3'd1, 1, 1, 0, 0, 1);
        push_exp("sp_r1",   2'b00, 3'd1, 0, 1, 0, 0, 3);
        push_exp("sp_res",  2'b01, 3'd0, 1, 1, 0, 0, 1);
        push_exp("sp_done", 2'b00, 3'd0, 0, 0, 0, 0, 1);
        step(2);  req = 2'b01;
        step(3);  split = 1'b1; req = 2'b11;
        step(1);  split = 1'b0;
        step(1);  split_resume = 1'b1;
        step(1);  split_resume = 1'b0;
        step(1);  txn_done = 1'b1; req = 2'b01;
        step(1);  txn_done = 1'b0;
        step(1);  txn_done = 1'b1; req = 2'b00;
        step(1);  txn_done = 1'b0;

        // Watchdog on owner 1, then a second split raises split_err.
        push_exp("to_g1",   2'b10, 3'd1, 1, 0, 0, 0, -1);
        push_exp("to_pulse",2'b00, 3'd1, 0, 0, 1, 0, 8);
        push_exp("to_g0",   2'b01, 3'd0, 1, 0, 0, 0, 1);
        push_exp("se_sp0",  2'b00, 3'd0, 0, 1, 0, 0, 1);
        push_exp("se_g1",   2'b10, 3'd1, 1, 1, 0, 0, 1);
        push_exp("se_err",  2'b00, 3'd1, 0, 1, 0, 1, 1);
        push_exp("se_g1b",  2'b10, 3'd1, 1, 1, 0, 0, 1);
        push_exp("se_vol",  2'b00, 3'd1, 0, 1, 0, 0, 1);
        push_exp("se_res0", 2'b01, 3'd0, 1, 1, 0, 0, 3);
        push_exp("se_done", 2'b00, 3'd0, 0, 0, 0, 0, 1);
        step(2);  req = 2'b10;
        step(1);  req = 2'b11;
        step(9);  split = 1'b1;
        step(1);  split = 1'b0;
        step(1);  split = 1'b1;
        step(1);  split = 1'b0;
        step(1);  req = 2'b01;
        step(2);  split_resume = 1'b1;
        step(1);  split_resume = 1'b0;
        step(1);  txn_done = 1'b1; req = 2'b00;
        step(1);  txn_done = 1'b0;

        // Stray pulses while idle and nothing outstanding: no output may move.
        step(2);  split_resume = 1'b1;
        step(1);  split_resume = 1'b0; txn_done = 1'b1;
        step(1);  txn_done = 1'b0; split = 1'b1;
        step(1);  split = 1'b0;
        step(3);
        @(negedge clk);
        chk("idle_pulses_ignored", dut_vec, '0);

        // Reset during ownership with a split outstanding, then arbitration restarts.
        push_exp("rs_g0",   2'b01, 3'd0, 1, 0, 0, 0, -1);
        push_exp("rs_sp",   2'b00, 3'd0, 0, 1, 0, 0, 1);
        push_exp("rs_g1",   2'b10, 3'd1, 1, 1, 0, 0, 1);
        push_exp("rs_rst",  2'b00, 3'd0, 0, 0, 0, 0, -1);
        push_exp("rs_a0",   2'b01, 3'd0, 1, 0, 0, 0, -1);
        push_exp("rs_ar0",  2'b00, 3'd0, 0, 0, 0, 0, 4);
`ifdef ARB_FIXED_PRIORITY_EN
        push_exp("rs_a1",   2'b01, 3'd0, 1, 0, 0, 0, 1);
        push_exp("rs_ar1",  2'b00, 3'd0, 0, 0, 0, 0, 4);
`else
        push_exp("rs_a1",   2'b10, 3'd1, 1, 0, 0, 0, 1);
        push_exp("rs_ar1",  2'b00, 3'd1, 0, 0, 0, 0, 4);
`endif
        step(1);  req = 2'b01;
        step(1);  split = 1'b1; req = 2'b11;
        step(1);  split = 1'b0;
        step(2);  rst_n = 1'b0;
        #1;
        chk("async_grant_clear", {7'd0, grant}, '0);
        chk("async_split_clear", {8'd0, split_pending}, '0);
        step(3);  rst_n = 1'b1;
        done_after(4, 2'b11);
        done_after(4, 2'b00);

        step(3);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step(1);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d pending expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
